ocm_arbiter: RTL and testbench
==============================

// Module: ocm_arbiter
// PURPOSE
//  Two-requester arbiter for the shared on-chip memory (OCM). Each core raises
//  request, receives grant, issues single-cycle accesses while granted, and
//  drops request to release. Mux sits between the cores and one synchronous
//  single-port OCM (1-cycle read latency). Round-robin on simultaneous request.
// PARAMETERS
//  ADDR_W    10   OCM word-address width (matches DATAMEM_BITS)
//  DATA_W    32   OCM data width
//  MAX_HOLD  64   max consecutive owned cycles before preemption (OCM_ARB_TIMEOUT_EN only), >=2
// PORTS
//  clk        in   1        system clock (CLK_BUF domain)
//  nrst       in   1        async active-low reset
//  request    in   2        [n]=core n wants the OCM; level, held for whole tenure
//  grant      out  2        one-hot-or-zero; [n]=core n owns the OCM
//  c0_valid   in   1        core0 access strobe (honoured only while grant[0])
//  c0_wr      in   4        core0 byte write enables; 0 = read
//  c0_addr    in   ADDR_W   core0 word address
//  c0_wdata   in   DATA_W   core0 write data
//  c0_done    out  1        1-cycle pulse: core0 access complete, rdata valid
//  c1_*       same as c0_* for core1
//  rdata      out  DATA_W   OCM read data, broadcast to both cores
//  ocm_en     out  1        OCM enable
//  ocm_wr     out  4        OCM byte write enables
//  ocm_addr   out  ADDR_W   OCM address
//  ocm_wdata  out  DATA_W   OCM write data
//  ocm_rdata  in   DATA_W   OCM read data (valid cycle after ocm_en)
//  preempt    out  1        1-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset: state IDLE, grant=0, last_owner=1 (core0 wins first tie), c*_done=0,
//   preempt=0, hold counter=0. ocm_* are combinational from grant, so ocm_en=0.
//  States: IDLE, OWN0, OWN1, TURN. grant[n]=1 exactly in OWNn (registered).
//  IDLE: req=00 stay; 01->OWN0; 10->OWN1; 11->OWN(~last_owner). Grant visible
//   the cycle after request is sampled high (min latency 1).
//  OWNn: stay while request[n]=1; request[n]=0 -> TURN, last_owner<=n.
//  TURN: one dead cycle, grant=0, then arbitrate as IDLE. Re-grant >=2 cycles
//   after release; other core waiting during tenure wins (round-robin).
//  Datapath: ocm_en=cn_valid&grant[n]; ocm_wr/addr/wdata = owner's inputs
//   when ocm_en, else 0. Non-owner inputs never reach OCM.
//  cn_done <= ocm_en & grant[n] (registered); rdata=ocm_rdata, valid with done.
//   Writes also get done. One access per cycle, throughput 1/cycle.
//  Access in the same cycle request[n] drops: still performed, done next cycle.
//  cn_valid without grant[n]: ignored, no done, no error.
//  Async reset mid-tenure: grant drops immediately, in-flight done discarded.
// CONFIGURATION
//  OCM_ARB_TIMEOUT_EN defined: hold counter clears on entry to OWNn, increments
//   each owned cycle, saturates at MAX_HOLD-1. At MAX_HOLD-1 with other request
//   high: go TURN, last_owner<=n, preempt pulses with the grant drop. Access in
//   the last owned cycle completes normally. Preempted core must keep or re-raise
//   request to be re-granted. Without other request: no preemption.
//  Not defined: no counter, preempt tied 0, tenure unbounded.
// TESTING
//  1 reset, request=01 at t0 -> grant=01 at t1; c0 write addr 5 data 0xDEADBEEF
//    -> ocm_wr=4'hF that cycle, c0_done next; c0 read addr 5 -> rdata=0xDEADBEEF w/ done.
//  2 request=11 from reset -> grant=01; drop req0 -> grant=00 one cycle -> grant=10;
//    repeat tie after both release -> core0 wins again (last_owner=1).
//  3 c1_valid=1 addr 7 wr=F while grant=01 -> ocm_en only for c0, OCM[7] unchanged,
//    c1_done never pulses.
//  4 c0 read issued same cycle req0 drops -> c0_done + correct rdata next cycle,
//    grant=00.
//  5 nrst low during OWN1 with c1_valid -> grant=00, done=0 immediately; recovers
//    to IDLE with last_owner=1.
//  6 (TIMEOUT_EN, MAX_HOLD=8) core0 holds req, core1 requests -> grant0 drops after
//    8 owned cycles, preempt pulses, grant=10 after TURN; alone, core0 never preempted.

Source files
------------

// File: rtl/ocm_arbiter_if.sv
// Bus bundle between the two cores, the OCM arbiter and the single-port OCM.
// slave = arbiter side, master = cores/OCM side.
interface ocm_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [1:0]        request;
  logic [1:0]        grant;
  logic              c0_valid;
  logic [3:0]        c0_wr;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_done;
  logic              c1_valid;
  logic [3:0]        c1_wr;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_done;
  logic [DATA_W-1:0] rdata;
  logic              ocm_en;
  logic [3:0]        ocm_wr;
  logic [ADDR_W-1:0] ocm_addr;
  logic [DATA_W-1:0] ocm_wdata;
  logic [DATA_W-1:0] ocm_rdata;
  logic              preempt;

  modport slave (
    input  request,
    input  c0_valid, c0_wr, c0_addr, c0_wdata,
    input  c1_valid, c1_wr, c1_addr, c1_wdata,
    input  ocm_rdata,
    output grant, c0_done, c1_done, rdata,
    output ocm_en, ocm_wr, ocm_addr, ocm_wdata, preempt
  );

  modport master (
    output request,
    output c0_valid, c0_wr, c0_addr, c0_wdata,
    output c1_valid, c1_wr, c1_addr, c1_wdata,
    output ocm_rdata,
    input  grant, c0_done, c1_done, rdata,
    input  ocm_en, ocm_wr, ocm_addr, ocm_wdata, preempt
  );
endinterface

// File: rtl/ocm_arbiter.sv
// Round-robin two-core arbiter and access mux for a single-port OCM.
// Optional hold-time preemption is enabled by defining OCM_ARB_TIMEOUT_EN.
module ocm_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input logic          clk,
  input logic          nrst,
  ocm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;

  state_t     state;
  state_t     arb_pick;
  logic [1:0] grant;
  logic       last_owner;
  logic       c0_done;
  logic       c1_done;
  logic       preempt_r;

`ifdef OCM_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_cnt;
`endif

  // On a tie the core that did not own the OCM last wins.
  function automatic state_t pick(input logic [1:0] req, input logic last);
    case (req)
      2'b01:   pick = OWN0;
      2'b10:   pick = OWN1;
      2'b11:   pick = last ? OWN0 : OWN1;
      default: pick = IDLE;
    endcase
  endfunction

  assign arb_pick = pick(bus.request, last_owner);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      c0_done    <= 1'b0;
      c1_done    <= 1'b0;
      preempt_r  <= 1'b0;
`ifdef OCM_ARB_TIMEOUT_EN
      hold_cnt   <= '0;
`endif
    end else begin
      c0_done   <= bus.c0_valid & grant[0];
      c1_done   <= bus.c1_valid & grant[1];
      preempt_r <= 1'b0;
      case (state)
        IDLE, TURN: begin
          state <= arb_pick;
          grant <= {arb_pick == OWN1, arb_pick == OWN0};
`ifdef OCM_ARB_TIMEOUT_EN
          hold_cnt <= '0;
`endif
        end
        OWN0: begin
          if (!bus.request[0]) begin
            state      <= TURN;
            grant      <= 2'b00;
            last_owner <= 1'b0;
          end
`ifdef OCM_ARB_TIMEOUT_EN
          else if (hold_cnt == HOLD_LAST && bus.request[1]) begin
            state      <= TURN;
            grant      <= 2'b00;
            last_owner <= 1'b0;
            preempt_r  <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        OWN1: begin
          if (!bus.request[1]) begin
            state      <= TURN;
            grant      <= 2'b00;
            last_owner <= 1'b1;
          end
`ifdef OCM_ARB_TIMEOUT_EN
          else if (hold_cnt == HOLD_LAST && bus.request[0]) begin
            state      <= TURN;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            preempt_r  <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Only the granted core's strobe can reach the OCM; everything else is zeroed.
  always_comb begin
    bus.ocm_en    = 1'b0;
    bus.ocm_wr    = 4'h0;
    bus.ocm_addr  = '0;
    bus.ocm_wdata = '0;
    if (bus.c0_valid && grant[0]) begin
      bus.ocm_en    = 1'b1;
      bus.ocm_wr    = bus.c0_wr;
      bus.ocm_addr  = bus.c0_addr;
      bus.ocm_wdata = bus.c0_wdata;
    end else if (bus.c1_valid && grant[1]) begin
      bus.ocm_en    = 1'b1;
      bus.ocm_wr    = bus.c1_wr;
      bus.ocm_addr  = bus.c1_addr;
      bus.ocm_wdata = bus.c1_wdata;
    end
  end

  assign bus.grant   = grant;
  assign bus.c0_done = c0_done;
  assign bus.c1_done = c1_done;
  assign bus.rdata   = bus.ocm_rdata;
  assign bus.preempt = preempt_r;

endmodule

// File: tb/tb_ocm_arbiter.sv
// Directed bench for ocm_arbiter with a byte-writable OCM model (1-cycle read).
// Inputs change on the falling edge; outputs are checked there or #1 after.
module tb_ocm_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic nrst;
  int   checks;
  int   passes;

  ocm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ocm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.ocm_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ocm_wr[b]) mem[bus.ocm_addr][b*8 +: 8] <= bus.ocm_wdata[b*8 +: 8];
      bus.ocm_rdata <= mem[bus.ocm_addr];
    end
  end

  task automatic idle_inputs();
    bus.request  = 2'b00;
    bus.c0_valid = 1'b0; bus.c0_wr = 4'h0; bus.c0_addr = '0; bus.c0_wdata = '0;
    bus.c1_valid = 1'b0; bus.c1_wr = 4'h0; bus.c1_addr = '0; bus.c1_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1'b0;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b00) $display("FAIL rst_grant got=%b exp=00", bus.grant); else passes++;
    checks++; if ({bus.c0_done, bus.c1_done} !== 2'b00) $display("FAIL rst_done got=%b exp=00", {bus.c0_done, bus.c1_done}); else passes++;
    checks++; if (bus.ocm_en !== 1'b0) $display("FAIL rst_ocm_en got=%b exp=0", bus.ocm_en); else passes++;
    checks++; if (bus.preempt !== 1'b0) $display("FAIL rst_preempt got=%b exp=0", bus.preempt); else passes++;
    nrst = 1'b1;
  endtask

  task automatic test_write_read();
    bus.request = 2'b01;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b01) $display("FAIL wr_grant got=%b exp=01", bus.grant); else passes++;
    bus.c0_valid = 1'b1; bus.c0_wr = 4'hF; bus.c0_addr = 10'd5; bus.c0_wdata = 32'hDEADBEEF;
    #1;
    checks++; if ({bus.ocm_en, bus.ocm_wr} !== 5'b1_1111) $display("FAIL wr_ocm_en_wr got=%b exp=11111", {bus.ocm_en, bus.ocm_wr}); else passes++;
    checks++; if (bus.ocm_addr !== 10'd5 || bus.ocm_wdata !== 32'hDEADBEEF) $display("FAIL wr_ocm_addr_data got=%0d/%h exp=5/deadbeef", bus.ocm_addr, bus.ocm_wdata); else passes++;
    @(negedge clk);
    checks++; if (bus.c0_done !== 1'b1) $display("FAIL wr_done got=%b exp=1", bus.c0_done); else passes++;
    bus.c0_wr = 4'h0; bus.c0_wdata = '0;
    @(negedge clk);
    checks++; if (bus.c0_done !== 1'b1) $display("FAIL rd_done got=%b exp=1", bus.c0_done); else passes++;
    checks++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", bus.rdata); else passes++;
    idle_inputs();
    @(negedge clk);
    checks++; if ({bus.grant, bus.c0_done} !== 3'b000) $display("FAIL rel_grant_done got=%b exp=000", {bus.grant, bus.c0_done}); else passes++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.request = 2'b11;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b01) $display("FAIL rr_tie1 got=%b exp=01", bus.grant); else passes++;
    bus.request = 2'b10;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b00) $display("FAIL rr_turn got=%b exp=00", bus.grant); else passes++;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b10) $display("FAIL rr_core1 got=%b exp=10", bus.grant); else passes++;
    bus.request = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.grant !== 2'b00) $display("FAIL rr_idle got=%b exp=00", bus.grant); else passes++;
    bus.request = 2'b11;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b01) $display("FAIL rr_tie2 got=%b exp=01", bus.grant); else passes++;
    bus.request = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_non_owner();
    mem[7] = 32'h12345678;
    mem[3] = 32'hA5A5_0003;
    bus.request = 2'b01;
    @(negedge clk);
    bus.c0_valid = 1'b1; bus.c0_wr = 4'h0; bus.c0_addr = 10'd3;
    bus.c1_valid = 1'b1; bus.c1_wr = 4'hF; bus.c1_addr = 10'd7; bus.c1_wdata = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.ocm_addr !== 10'd3 || bus.ocm_wr !== 4'h0) $display("FAIL no_addr_wr got=%0d/%h exp=3/0", bus.ocm_addr, bus.ocm_wr); else passes++;
    @(negedge clk);
    checks++; if ({bus.c0_done, bus.c1_done} !== 2'b10) $display("FAIL no_done got=%b exp=10", {bus.c0_done, bus.c1_done}); else passes++;
    checks++; if (bus.rdata !== 32'hA5A5_0003) $display("FAIL no_rdata got=%h exp=a5a50003", bus.rdata); else passes++;
    bus.c0_valid = 1'b0;
    #1;
    checks++; if (bus.ocm_en !== 1'b0) $display("FAIL no_ocm_en got=%b exp=0", bus.ocm_en); else passes++;
    @(negedge clk);
    checks++; if (bus.c1_done !== 1'b0) $display("FAIL no_c1_done got=%b exp=0", bus.c1_done); else passes++;
    checks++; if (mem[7] !== 32'h12345678) $display("FAIL no_mem7 got=%h exp=12345678", mem[7]); else passes++;
    bus.c1_valid = 1'b0; bus.c1_wr = 4'h0; bus.c1_wdata = '0;
  endtask

  task automatic test_drop_with_access();
    bus.c0_valid = 1'b1; bus.c0_wr = 4'h0; bus.c0_addr = 10'd5;
    bus.request = 2'b00;
    @(negedge clk);
    checks++; if (bus.c0_done !== 1'b1) $display("FAIL drop_done got=%b exp=1", bus.c0_done); else passes++;
    checks++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL drop_rdata got=%h exp=deadbeef", bus.rdata); else passes++;
    checks++; if (bus.grant !== 2'b00) $display("FAIL drop_grant got=%b exp=00", bus.grant); else passes++;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.request = 2'b10;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b10) $display("FAIL ar_grant1 got=%b exp=10", bus.grant); else passes++;
    bus.c1_valid = 1'b1; bus.c1_addr = 10'd5;
    @(posedge clk);
    #2;
    checks++; if (bus.c1_done !== 1'b1) $display("FAIL ar_done_before got=%b exp=1", bus.c1_done); else passes++;
    nrst = 1'b0;
    #1;
    checks++; if ({bus.grant, bus.c1_done, bus.ocm_en} !== 4'b0000) $display("FAIL ar_cleared got=%b exp=0000", {bus.grant, bus.c1_done, bus.ocm_en}); else passes++;
    idle_inputs();
    @(negedge clk);
    nrst = 1'b1;
    bus.request = 2'b11;
    @(negedge clk);
    checks++; if (bus.grant !== 2'b01) $display("FAIL ar_recover_tie got=%b exp=01", bus.grant); else passes++;
  endtask

  task automatic test_timeout();
    int owned;
    int pulses;
    owned  = 1;
    pulses = 0;
    // Core0 owns with core1 already waiting (request=11 left from previous task).
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.preempt) pulses++;
      if (bus.grant[0]) owned++;
      else break;
    end
`ifdef OCM_ARB_TIMEOUT_EN
    checks++; if (owned !== MAX_HOLD) $display("FAIL to_owned got=%0d exp=%0d", owned, MAX_HOLD); else passes++;
    checks++; if ({bus.grant, bus.preempt} !== 3'b001) $display("FAIL to_preempt got=%b exp=001", {bus.grant, bus.preempt}); else passes++;
    @(negedge clk);
    checks++; if ({bus.grant, bus.preempt} !== 3'b100) $display("FAIL to_core1 got=%b exp=100", {bus.grant, bus.preempt}); else passes++;
    bus.request = 2'b01;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.grant !== 2'b01) $display("FAIL to_core0_back got=%b exp=01", bus.grant); else passes++;
    pulses = 0;
    owned  = 0;
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      @(negedge clk);
      if (bus.preempt) pulses++;
      if (bus.grant[0]) owned++;
    end
    checks++; if (owned !== 3 * MAX_HOLD || pulses !== 0) $display("FAIL to_alone got=%0d/%0d exp=%0d/0", owned, pulses, 3 * MAX_HOLD); else passes++;
`else
    checks++; if (owned !== 31 || pulses !== 0) $display("FAIL nto_hold got=%0d/%0d exp=31/0", owned, pulses); else passes++;
`endif
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    bus.ocm_rdata = '0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_non_owner();
    test_drop_with_access();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
